alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Upstream command front-end for the 8-bit ALU top.
- Accepts {op, A, B} commands over a valid/ready interface and buffers them in a small FIFO.
- Issues each command to the ALU with a one-cycle start pulse and holds the operands stable until the ALU signals done.
- Returns the captured 16-bit result over a valid/ready response interface, in command order, with a watchdog timeout flag.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
TIMEOUT, 63, maximum WAIT cycles before the sequencer abandons the op (>=40, covers 8-step MUL/DIV)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high; clears all state
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO not full; a command transfers when cmd_valid&&cmd_ready
cmd_op  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
cmd_a  input  8  operand A
cmd_b  input  8  operand B
alu_start  output  1  one-cycle start pulse to the ALU
alu_op_code  output  2  op held during operation
alu_operand_A  output  8  held operand A
alu_operand_B  output  8  held operand B
alu_result  input  16  ALU result ({rem,quot} for DIV)
alu_done  input  1  ALU completion
rsp_valid  output  1  response held until accepted
rsp_ready  input  1  consumer accepts response
rsp_op  output  2  op of returned response
rsp_result  output  16  captured result
rsp_timeout  output  1  response produced by the watchdog, not by the ALU
busy  output  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (asynchronous, immediate):
  - State=IDLE; FIFO pointers/count=0.
  - alu_start=0; alu_op_code/operands=0; rsp_valid=0; rsp_result=0; rsp_op=0; rsp_timeout=0; cmd_ready=1; busy=0.
  - Reset mid-operation discards all queued and in-flight commands; no response is produced for them.
- FIFO:
  - Push on cmd_valid&&cmd_ready; pop only from IDLE.
  - cmd_ready = (count != DEPTH), registered-count based; no bypass when full.
  - Simultaneous push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- FSM states IDLE, ISSUE, GUARD, WAIT, RESP:
  - IDLE: if FIFO non-empty, pop the head into the alu_op_code/operand registers and go to ISSUE; otherwise stay.
  - ISSUE: alu_start=1 for exactly this cycle; go to GUARD.
  - GUARD: one cycle; alu_done is ignored (masks a done left over from the previous op); watchdog counter cleared; go to WAIT.
  - WAIT: if alu_done=1, capture alu_result into rsp_result, set rsp_op=alu_op_code and rsp_timeout=0, then go to RESP. Else, if the counter == TIMEOUT-1, set rsp_result=16'h0000 and rsp_timeout=1, then go to RESP. Else increment the counter.
  - RESP: rsp_valid=1; rsp_op, rsp_result and rsp_timeout stay stable. On rsp_ready go to IDLE and drop rsp_valid on the next cycle.
- Operand and op outputs change only on a pop; they are stable from ISSUE through RESP.
- Latency from command accepted at edge T (FIFO previously empty, sequencer in IDLE):
  - Pop at T+1.
  - alu_start high in cycle T+1..T+2.
  - Earliest capture at edge T+4 (done seen in the first WAIT cycle).
- Ordering: at most one command in flight; responses are returned strictly in acceptance order.
- rsp_ready held low stalls in RESP indefinitely. The FIFO keeps accepting until full.
- Widths: no arithmetic on data; the watchdog counter is $clog2(TIMEOUT+1) bits and saturates in no case beyond TIMEOUT-1.

Decomposition:
- Package alu_seq_pkg:
  - Op-code constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11.
  - FSM state encoding.
  - Command word width (18) and field offsets.
- Sub-module alu_cmd_fifo: parameterised DEPTH×18 synchronous FIFO with push, pop, full, empty and count. It uses the same asynchronous active-high reset.

Test Plan:
- ADD 16+77, rsp_ready=1 -> one alu_start pulse; rsp_result=16'h005D, rsp_op=00, rsp_timeout=0.
- SUB 41-22, MUL 113*13, DIV 244/27 sent back-to-back -> responses in order: 16'h0013, 16'h05BD, 16'h0109 (rem 1, quot 9); exactly three start pulses.
- rsp_ready=0 and six commands offered -> first in flight; four queued; cmd_ready=0 from the sixth; releasing rsp_ready drains all five in order with no loss.
- ALU stub that never asserts done -> after TIMEOUT WAIT cycles: rsp_valid=1, rsp_timeout=1, rsp_result=0. The next command issues normally.
- Stale alu_done held high entering GUARD -> ignored in GUARD, captured in WAIT; the result corresponds to the new operands.
- reset asserted during WAIT with 2 commands queued -> all outputs return to their reset values asynchronously. No response follows; busy=0 after reset release.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: op codes, FSM states
// and the layout of a queued command word.
package alu_seq_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int CMD_W      = 18;
    localparam int CMD_B_LSB  = 0;
    localparam int CMD_A_LSB  = 8;
    localparam int CMD_OP_LSB = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GUARD,
        ST_WAIT,
        ST_RESP
    } seq_state_t;

    // Command word is {op, A, B}, op in the top bits.
    function automatic logic [CMD_W-1:0] pack_cmd(input logic [1:0] op,
                                                  input logic [7:0] a,
                                                  input logic [7:0] b);
        return {op, a, b};
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// DEPTH x WIDTH synchronous FIFO with registered occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the 8-bit ALU: queues {op,A,B} commands, issues them
// one at a time and returns results (or watchdog timeouts) in order.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic        alu_start,
    output logic [1:0]  alu_op_code,
    output logic [7:0]  alu_operand_A,
    output logic [7:0]  alu_operand_B,
    input  logic [15:0] alu_result,
    input  logic        alu_done,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_op,
    output logic [15:0] rsp_result,
    output logic        rsp_timeout,
    output logic        busy
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int WD_W  = $clog2(TIMEOUT+1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT-1);

    seq_state_t        state;
    seq_state_t        next_state;
    logic [CMD_W-1:0]  head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              pop;
    logic              capture;
    logic              expire;
    logic [WD_W-1:0]   wd_cnt;

    assign cmd_ready = !fifo_full;
    assign busy      = (state != ST_IDLE) || (fifo_count != '0);

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (cmd_valid && cmd_ready),
        .pop     (pop),
        .wr_data (pack_cmd(cmd_op, cmd_a, cmd_b)),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // GUARD exists only to swallow a done pulse still asserted from the previous op.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        capture    = 1'b0;
        expire     = 1'b0;
        alu_start  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                alu_start  = 1'b1;
                next_state = ST_GUARD;
            end
            ST_GUARD: next_state = ST_WAIT;
            ST_WAIT: begin
                if (alu_done) begin
                    capture    = 1'b1;
                    next_state = ST_RESP;
                end else if (wd_cnt == WD_LAST) begin
                    expire     = 1'b1;
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Operands load only on a pop, so they stay put from ISSUE through RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_op_code   <= OP_ADD;
            alu_operand_A <= '0;
            alu_operand_B <= '0;
            wd_cnt        <= '0;
            rsp_op        <= OP_ADD;
            rsp_result    <= '0;
            rsp_timeout   <= 1'b0;
        end else begin
            if (pop) begin
                alu_op_code   <= head[CMD_OP_LSB +: 2];
                alu_operand_A <= head[CMD_A_LSB +: 8];
                alu_operand_B <= head[CMD_B_LSB +: 8];
            end
            if (state == ST_GUARD)
                wd_cnt <= '0;
            else if (state == ST_WAIT && !capture && !expire)
                wd_cnt <= wd_cnt + 1'b1;
            if (capture) begin
                rsp_result  <= alu_result;
                rsp_op      <= alu_op_code;
                rsp_timeout <= 1'b0;
            end else if (expire) begin
                rsp_result  <= 16'h0000;
                rsp_op      <= alu_op_code;
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU stub, expected-response queue
// and one task per scenario.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 63;

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] result;
        logic        timeout;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [7:0]  cmd_a = 8'h00;
    logic [7:0]  cmd_b = 8'h00;
    logic        alu_start;
    logic [1:0]  alu_op_code;
    logic [7:0]  alu_operand_A;
    logic [7:0]  alu_operand_B;
    logic [15:0] alu_result;
    logic        alu_done;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_op;
    logic [15:0] rsp_result;
    logic        rsp_timeout;
    logic        busy;

    rsp_t exp_q[$];
    rsp_t got_q[$];
    int   checks = 0;
    int   errors = 0;
    int   start_cnt = 0;
    int   stub_mode = 0;
    int   stub_max_lat = 0;
    int   rsp_mode = 1;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .alu_start     (alu_start),
        .alu_op_code   (alu_op_code),
        .alu_operand_A (alu_operand_A),
        .alu_operand_B (alu_operand_B),
        .alu_result    (alu_result),
        .alu_done      (alu_done),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_op        (rsp_op),
        .rsp_result    (rsp_result),
        .rsp_timeout   (rsp_timeout),
        .busy          (busy)
    );

    // What the 8-bit ALU computes; DIV returns {rem,quot}.
    function automatic logic [15:0] ref_result(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int ia;
        int ib;
        ia = int'(a);
        ib = int'(b);
        case (op)
            OP_ADD:  return 16'(ia + ib);
            OP_SUB:  return 16'((ia - ib) & 255);
            OP_MUL:  return 16'(ia * ib);
            default: begin
                if (ib == 0) return 16'hFFFF;
                return 16'(((ia % ib) << 8) | (ia / ib));
            end
        endcase
    endfunction

    // ALU stub. Mode 0: done after a random delay; 1: never done;
    // 2: done stuck high with the result of whatever operands are presented.
    logic        done_reg;
    logic [15:0] res_reg;
    logic        stub_busy;
    int          lat_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            done_reg  <= 1'b0;
            res_reg   <= 16'h0000;
            stub_busy <= 1'b0;
            lat_cnt   <= 0;
        end else begin
            done_reg <= 1'b0;
            if (alu_start) begin
                stub_busy <= (stub_mode != 1);
                lat_cnt   <= int'($urandom_range(stub_max_lat, 0));
                res_reg   <= ref_result(alu_op_code, alu_operand_A, alu_operand_B);
            end else if (stub_busy) begin
                if (lat_cnt == 0) begin
                    done_reg  <= 1'b1;
                    stub_busy <= 1'b0;
                end else begin
                    lat_cnt <= lat_cnt - 1;
                end
            end
        end
    end

    assign alu_done   = (stub_mode == 2) ? 1'b1 : done_reg;
    assign alu_result = (stub_mode == 2) ? ref_result(alu_op_code, alu_operand_A, alu_operand_B) : res_reg;

    // Response consumer: 0 stalls, 1 always ready, 2 random.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rsp_mode)
                0:       rsp_ready = 1'b0;
                1:       rsp_ready = 1'b1;
                default: rsp_ready = 1'($urandom_range(1, 0));
            endcase
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            if (alu_start) start_cnt++;
            if (rsp_valid && rsp_ready) got_q.push_back({rsp_op, rsp_result, rsp_timeout});
        end
    end

    // Called #1 after an edge; returns #1 after the accepting edge.
    task automatic send_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int waited;
        waited = 0;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && waited < 500) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("[TB] FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, waited);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (stub_mode == 1) exp_q.push_back({op, 16'h0000, 1'b1});
        else                exp_q.push_back({op, ref_result(op, a, b), 1'b0});
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsps(input int n, input int budget, output bit ok);
        int c;
        c = 0;
        while (got_q.size() < n && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        ok = (got_q.size() >= n);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({alu_start, rsp_valid, rsp_timeout, busy, cmd_ready} !== 5'b00001) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: {start,rvalid,rtimeout,busy,cready}=%b, required 00001",
                     {alu_start, rsp_valid, rsp_timeout, busy, cmd_ready});
        end
        checks++;
        if ({alu_op_code, alu_operand_A, alu_operand_B} !== 18'h0) begin
            errors++;
            $display("[TB] FAIL reset_operands: got %h, required 0", {alu_op_code, alu_operand_A, alu_operand_B});
        end
        checks++;
        if ({rsp_op, rsp_result} !== 18'h0) begin
            errors++;
            $display("[TB] FAIL reset_rsp: got %h, required 0", {rsp_op, rsp_result});
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release: busy=%b cmd_ready=%b, required 0/1", busy, cmd_ready);
        end
    endtask

    task automatic test_add();
        int   s0;
        bit   ok;
        rsp_t g;
        rsp_t e;
        stub_mode = 0;
        stub_max_lat = 0;
        rsp_mode = 1;
        s0 = start_cnt;
        send_cmd(OP_ADD, 8'd16, 8'd77);
        @(posedge clk); #1;
        checks++;
        if (alu_start !== 1'b1 || alu_op_code !== OP_ADD || alu_operand_A !== 8'd16 || alu_operand_B !== 8'd77) begin
            errors++;
            $display("[TB] FAIL add_issue: start=%b op=%b A=%0d B=%0d, required 1/00/16/77",
                     alu_start, alu_op_code, alu_operand_A, alu_operand_B);
        end
        @(posedge clk); #1;
        checks++;
        if (alu_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_pulse_width: alu_start=%b one cycle after issue, required 0", alu_start);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_early_rsp: rsp_valid=%b at T+3, required 0", rsp_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 16'h005D || rsp_op !== 2'b00 || rsp_timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_rsp: valid=%b result=%h op=%b to=%b, required 1/005d/00/0",
                     rsp_valid, rsp_result, rsp_op, rsp_timeout);
        end
        wait_rsps(1, 20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL add_handshake: %0d responses, required 1", got_q.size());
        end else begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("[TB] FAIL add_scoreboard: got %h, required %h", g, e);
            end
        end
        checks++;
        if (start_cnt - s0 !== 1) begin
            errors++;
            $display("[TB] FAIL add_start_count: %0d pulses, required 1", start_cnt - s0);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] want_res [3];
        logic [1:0]  want_op  [3];
        int   s0;
        bit   ok;
        rsp_t g;
        rsp_t e;
        want_res[0] = 16'h0013; want_op[0] = OP_SUB;
        want_res[1] = 16'h05BD; want_op[1] = OP_MUL;
        want_res[2] = 16'h0109; want_op[2] = OP_DIV;
        stub_mode = 0;
        stub_max_lat = 8;
        rsp_mode = 1;
        s0 = start_cnt;
        send_cmd(OP_SUB, 8'd41, 8'd22);
        send_cmd(OP_MUL, 8'd113, 8'd13);
        send_cmd(OP_DIV, 8'd244, 8'd27);
        wait_rsps(3, 200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL b2b_count: %0d responses, required 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                checks++;
                if (g.result !== want_res[i] || g.op !== want_op[i] || g.timeout !== 1'b0 || e.result !== want_res[i]) begin
                    errors++;
                    $display("[TB] FAIL b2b_rsp%0d: result=%h op=%b to=%b, required %h/%b/0",
                             i, g.result, g.op, g.timeout, want_res[i], want_op[i]);
                end
            end
        end
        checks++;
        if (start_cnt - s0 !== 3) begin
            errors++;
            $display("[TB] FAIL b2b_start_count: %0d pulses, required 3", start_cnt - s0);
        end
    endtask

    task automatic test_backpressure();
        bit          ok;
        rsp_t        g;
        rsp_t        e;
        logic [15:0] first;
        stub_mode = 0;
        stub_max_lat = 6;
        rsp_mode = 0;
        for (int i = 0; i < 5; i++) send_cmd(2'($urandom), 8'($urandom), 8'($urandom_range(255, 1)));
        first = exp_q[0].result;
        repeat (20) @(posedge clk);
        #1;
        cmd_op = 2'($urandom);
        cmd_a = 8'($urandom);
        cmd_b = 8'($urandom);
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_result !== first || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL stall_cycle%0d: cready=%b rvalid=%b result=%h busy=%b, required 0/1/%h/1",
                         i, cmd_ready, rsp_valid, rsp_result, busy, first);
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL stall_leak: %0d responses while stalled, required 0", got_q.size());
        end
        rsp_mode = 1;
        wait_rsps(5, 400, ok);
        checks++;
        if (!ok || got_q.size() != 5) begin
            errors++;
            $display("[TB] FAIL drain_count: %0d responses, required 5", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("[TB] FAIL drain_order: got %h, required %h", g, e);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_timeout();
        bit   ok;
        rsp_t g;
        rsp_t e;
        stub_mode = 1;
        rsp_mode = 1;
        send_cmd(OP_MUL, 8'($urandom), 8'($urandom));
        repeat (TIMEOUT + 2) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_early: rsp_valid=%b one cycle before expiry, required 0", rsp_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_result !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL timeout_rsp: valid=%b to=%b result=%h, required 1/1/0000",
                     rsp_valid, rsp_timeout, rsp_result);
        end
        wait_rsps(1, 20, ok);
        if (ok) begin
            void'(got_q.pop_front());
            void'(exp_q.pop_front());
        end
        stub_mode = 0;
        stub_max_lat = 4;
        send_cmd(OP_SUB, 8'($urandom), 8'($urandom));
        wait_rsps(1, 100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL after_timeout_count: %0d responses, required 1", got_q.size());
        end else begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("[TB] FAIL after_timeout_rsp: got %h, required %h", g, e);
            end
        end
    endtask

    task automatic test_stale_done();
        bit          ok;
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] want;
        rsp_t        g;
        op = OP_DIV;
        a = 8'($urandom);
        b = 8'($urandom_range(255, 1));
        want = ref_result(op, a, b);
        stub_mode = 2;
        rsp_mode = 1;
        send_cmd(op, a, b);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stale_guard: rsp_valid=%b at T+3 with done high, required 0", rsp_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== want || rsp_timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stale_capture: valid=%b result=%h to=%b, required 1/%h/0",
                     rsp_valid, rsp_result, rsp_timeout, want);
        end
        wait_rsps(1, 20, ok);
        if (ok) begin
            g = got_q.pop_front();
            void'(exp_q.pop_front());
            checks++;
            if (g.result !== want || g.op !== op) begin
                errors++;
                $display("[TB] FAIL stale_rsp: result=%h op=%b, required %h/%b", g.result, g.op, want, op);
            end
        end
        stub_mode = 0;
    endtask

    task automatic test_random();
        bit   ok;
        rsp_t g;
        rsp_t e;
        int   n;
        n = 40;
        stub_mode = 0;
        stub_max_lat = 12;
        rsp_mode = 2;
        for (int i = 0; i < n; i++) begin
            send_cmd(2'($urandom), 8'($urandom), 8'($urandom));
            repeat ($urandom_range(3, 0)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_rsps(n, 4000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL random_count: %0d responses, required %0d", got_q.size(), n);
        end
        for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("[TB] FAIL random_rsp%0d: got %h, required %h", i, g, e);
            end
        end
        rsp_mode = 1;
    endtask

    task automatic test_reset_mid_op();
        int s0;
        stub_mode = 1;
        rsp_mode = 1;
        for (int i = 0; i < 3; i++) send_cmd(2'($urandom), 8'($urandom), 8'($urandom));
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({alu_start, rsp_valid, rsp_timeout, busy, cmd_ready} !== 5'b00001 ||
            {alu_op_code, alu_operand_A, alu_operand_B} !== 18'h0 || {rsp_op, rsp_result} !== 18'h0) begin
            errors++;
            $display("[TB] FAIL async_reset: ctrl=%b ops=%h rsp=%h, required 00001/0/0",
                     {alu_start, rsp_valid, rsp_timeout, busy, cmd_ready},
                     {alu_op_code, alu_operand_A, alu_operand_B}, {rsp_op, rsp_result});
        end
        exp_q.delete();
        got_q.delete();
        stub_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        s0 = start_cnt;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flush: busy=%b rsp_valid=%b, required 0/0", busy, rsp_valid);
        end
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != 0 || start_cnt != s0) begin
            errors++;
            $display("[TB] FAIL reset_ghost: %0d responses, %0d starts after reset, required 0/0",
                     got_q.size(), start_cnt - s0);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_stale_done();
        test_random();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
